// File: rtl/coarse_pkg.sv
// Shared constants, types and the switch-decode function for the coarse
// summer/comparator controller.
package coarse_pkg;

    // Twelve switch drives; bit i of a switch vector is DC(i+1).
    localparam int N_SW = 12;

    localparam int DC9_IDX  = 8;
    localparam int DC10_IDX = 9;
    localparam int DC11_IDX = 10;
    localparam int DC12_IDX = 11;

    // Octant switch pairs among DC1..DC8. Octant 0 is {DC3, DC5}; each later
    // octant rotates the pair one switch position (45 deg) around the ring.
    localparam logic [7:0] COARSE_OCT_SW [0:7] = '{
        8'h14,  // oct 0: DC3, DC5
        8'h28,  // oct 1: DC4, DC6
        8'h50,  // oct 2: DC5, DC7
        8'hA0,  // oct 3: DC6, DC8
        8'h41,  // oct 4: DC7, DC1
        8'h82,  // oct 5: DC8, DC2
        8'h05,  // oct 6: DC1, DC3
        8'h0A   // oct 7: DC2, DC4
    };

    typedef enum logic {
        ST_SETTLE = 1'b0,
        ST_SAMPLE = 1'b1
    } coarse_state_e;

    // Active-high switch vector for counter bits [15:9].
    function automatic logic [N_SW-1:0] sw_decode(input logic [6:0] cnt_hi);
        logic [N_SW-1:0] sw;
        sw           = '0;
        sw[7:0]      = COARSE_OCT_SW[cnt_hi[6:4]];
        sw[DC9_IDX]  = ~cnt_hi[3];
        sw[DC10_IDX] = cnt_hi[2];
        sw[DC11_IDX] = cnt_hi[1];
        sw[DC12_IDX] = cnt_hi[0];
        return sw;
    endfunction

endpackage

// File: rtl/coarse_sw_decode.sv
// Combinational decode of the counter's upper bits into the twelve
// active-high switch enables. The parent registers the result.
module coarse_sw_decode
    import coarse_pkg::*;
(
    input  logic [6:0]      cnt_hi,
    output logic [N_SW-1:0] sw
);

    // Pure table/bit decode; no state.
    always_comb begin
        sw = sw_decode(cnt_hi);
    end

endmodule

// File: rtl/coarse_ctl.sv
// Coarse-system controller: owns the read counter, drives the resolver
// sum switches, and slews the counter until the comparators null.
module coarse_ctl
    import coarse_pkg::*;
#(
    parameter int SETTLE    = 8,
    parameter int STEP      = 64,
    parameter int ADHI_FILT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        _TLC1H,
    input  logic        _TLC2H,
    input  logic        _ADHI,
    input  logic        fine_up,
    input  logic        fine_dn,
    input  logic        load,
    input  logic [15:0] load_val,
    output logic        _DC1,
    output logic        _DC2,
    output logic        _DC3,
    output logic        _DC4,
    output logic        _DC5,
    output logic        _DC6,
    output logic        _DC7,
    output logic        _DC8,
    output logic        _DC9,
    output logic        _DC10,
    output logic        _DC11,
    output logic        _DC12,
    output logic [15:0] cnt,
    output logic        cpulse_up,
    output logic        cpulse_dn,
    output logic        coarse_err,
    output logic        tlc_fault
);

    localparam int TW = (SETTLE > 2) ? $clog2(SETTLE) : 1;
    localparam int FW = $clog2(ADHI_FILT + 1);
    localparam logic [TW-1:0]   TIMER_LAST = TW'(SETTLE - 1);
    localparam logic [FW-1:0]   FILT_LAST  = FW'(ADHI_FILT - 1);
    localparam logic [N_SW-1:0] DC_N_RST   = ~sw_decode(7'd0);

    logic [1:0]      tlc1_sync, tlc2_sync, adhi_sync;
    logic [1:0]      prime;
    logic            primed;
    logic [N_SW-1:0] sw_next;
    logic [N_SW-1:0] dc_n_q;
    logic            dc_change;
    coarse_state_e   state, state_nxt;
    logic [TW-1:0]   timer;
    logic [FW-1:0]   filt;
    logic            do_sample;
    logic            lag, lead, adhi;
    logic            step_up, step_dn, both, nulled, flip, fine_ok;

    // Two-flop synchronizers; reset to the deasserted level of each input.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            tlc1_sync <= 2'b11;
            tlc2_sync <= 2'b11;
            adhi_sync <= 2'b00;
        end else begin
            tlc1_sync <= {tlc1_sync[0], _TLC1H};
            tlc2_sync <= {tlc2_sync[0], _TLC2H};
            adhi_sync <= {adhi_sync[0], _ADHI};
        end
    end

    assign lag  = ~tlc1_sync[1];
    assign lead = ~tlc2_sync[1];
    assign adhi = adhi_sync[1];

    // Hold the settle timer after reset until the sync and decode stages
    // carry post-reset data (two sync stages plus one decode register).
    always_ff @(posedge clk) begin
        if (rst)          prime <= 2'd0;
        else if (!primed) prime <= prime + 2'd1;
    end

    assign primed = (prime == 2'd3);

    coarse_sw_decode u_decode (
        .cnt_hi (cnt[15:9]),
        .sw     (sw_next)
    );

    assign dc_change = (~sw_next) != dc_n_q;

    // Registered active-low switch drives.
    always_ff @(posedge clk) begin
        if (rst) dc_n_q <= DC_N_RST;
        else     dc_n_q <= ~sw_next;
    end

    assign {_DC12, _DC11, _DC10, _DC9, _DC8, _DC7,
            _DC6,  _DC5,  _DC4,  _DC3, _DC2, _DC1} = dc_n_q;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_SETTLE;
        else     state <= state_nxt;
    end

    // FSM next state: settle until the timer expires, sample for one cycle.
    always_comb begin
        // NOTE: default first so no path leaves state_nxt unassigned (no latch).
        state_nxt = state;
        case (state)
            ST_SETTLE: if (primed && !dc_change && timer == TIMER_LAST) state_nxt = ST_SAMPLE;
            ST_SAMPLE: state_nxt = ST_SETTLE;
            default:   state_nxt = ST_SETTLE;
        endcase
        if (load) state_nxt = ST_SETTLE;
    end

    // FSM outputs.
    always_comb begin
        do_sample = (state == ST_SAMPLE);
    end

    // Settle timer; restarts on load, on a sample, and whenever the switch
    // drives are about to change.
    always_ff @(posedge clk) begin
        if (rst || load || dc_change || !primed || do_sample) timer <= '0;
        else if (timer != TIMER_LAST)                          timer <= timer + 1'b1;
    end

    // Sample outcome decode.
    always_comb begin
        step_up = do_sample && lag && !lead;
        step_dn = do_sample && lead && !lag;
        both    = lag && lead;
        nulled  = !lag && !lead;
        flip    = do_sample && nulled && adhi && (filt == FILT_LAST);
        fine_ok = !coarse_err && !step_up && !step_dn && !flip;
    end

    // Read counter: load, then coarse step or flip, then fine count.
    always_ff @(posedge clk) begin
        if (rst)                               cnt <= 16'h0000;
        else if (load)                         cnt <= load_val;
        else if (step_up)                      cnt <= cnt + 16'(STEP);
        else if (step_dn)                      cnt <= cnt - 16'(STEP);
        else if (flip)                         cnt <= cnt ^ 16'h8000;
        else if (fine_ok && fine_up && !fine_dn) cnt <= cnt + 16'd1;
        else if (fine_ok && fine_dn && !fine_up) cnt <= cnt - 16'd1;
    end

    // Sample status, step pulses and the ambiguity filter.
    always_ff @(posedge clk) begin
        if (rst || load) begin
            cpulse_up  <= 1'b0;
            cpulse_dn  <= 1'b0;
            coarse_err <= 1'b0;
            tlc_fault  <= 1'b0;
            filt       <= '0;
        end else begin
            cpulse_up <= step_up;
            cpulse_dn <= step_dn;
            if (do_sample) begin
                coarse_err <= !nulled;
                tlc_fault  <= both;
                if (nulled && adhi && !flip) filt <= filt + 1'b1;
                else                         filt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_coarse_ctl.sv
// Directed self-checking bench for coarse_ctl.
module tb_coarse_ctl;

    logic        clk = 1'b0;
    logic        rst;
    logic        tlc1_n, tlc2_n, adhi;
    logic        fine_up, fine_dn, load;
    logic [15:0] load_val;
    logic [11:0] dc_n;
    logic [15:0] cnt;
    logic        cpulse_up, cpulse_dn, coarse_err, tlc_fault;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    coarse_ctl dut (
        .clk        (clk),
        .rst        (rst),
        ._TLC1H     (tlc1_n),
        ._TLC2H     (tlc2_n),
        ._ADHI      (adhi),
        .fine_up    (fine_up),
        .fine_dn    (fine_dn),
        .load       (load),
        .load_val   (load_val),
        ._DC1       (dc_n[0]),
        ._DC2       (dc_n[1]),
        ._DC3       (dc_n[2]),
        ._DC4       (dc_n[3]),
        ._DC5       (dc_n[4]),
        ._DC6       (dc_n[5]),
        ._DC7       (dc_n[6]),
        ._DC8       (dc_n[7]),
        ._DC9       (dc_n[8]),
        ._DC10      (dc_n[9]),
        ._DC11      (dc_n[10]),
        ._DC12      (dc_n[11]),
        .cnt        (cnt),
        .cpulse_up  (cpulse_up),
        .cpulse_dn  (cpulse_dn),
        .coarse_err (coarse_err),
        .tlc_fault  (tlc_fault)
    );

    typedef struct {
        logic [15:0] load_val;
        logic [11:0] dc_n;
    } vec_t;

    vec_t vecs [10];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Ticks until the selected condition holds; n = ticks taken, -1 on timeout.
    // which: 0 cpulse_up, 1 cpulse_dn, 2 tlc_fault, 3 coarse_err low.
    task automatic wait_for(input int which, input int limit, output int n);
        logic hit;
        n = -1;
        for (int i = 1; i <= limit; i++) begin
            tick();
            case (which)
                0:       hit = cpulse_up;
                1:       hit = cpulse_dn;
                2:       hit = tlc_fault;
                default: hit = !coarse_err;
            endcase
            if (hit) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic do_load(input logic [15:0] v);
        load     = 1'b1;
        load_val = v;
        tick();
        load     = 1'b0;
    endtask

    initial begin
        int n;
        int pulses;

        // Expected active-low vectors {_DC12.._DC1} after loading each value.
        vecs[0] = '{16'h0000, 12'hEEB};  // oct0, DC9
        vecs[1] = '{16'h2000, 12'hED7};  // oct1, DC9
        vecs[2] = '{16'h1000, 12'hFEB};  // oct0, no DC9
        vecs[3] = '{16'h0E00, 12'h0EB};  // oct0, DC9..DC12
        vecs[4] = '{16'h8000, 12'hEBE};  // oct4, DC9
        vecs[5] = '{16'hFFE0, 12'h1F5};  // oct7, DC10..DC12
        vecs[6] = '{16'h4400, 12'hAAF};  // oct2, DC9, DC11
        vecs[7] = '{16'hA200, 12'h67D};  // oct5, DC9, DC12
        vecs[8] = '{16'h6000, 12'hE5F};  // oct3, DC9
        vecs[9] = '{16'hC000, 12'hEFA};  // oct6, DC9

        rst = 1'b1; tlc1_n = 1'b1; tlc2_n = 1'b1; adhi = 1'b0;
        fine_up = 1'b0; fine_dn = 1'b0; load = 1'b0; load_val = 16'h0000;
        tick(); tick(); tick();

        check("rst_cnt",   32'(cnt), 32'h0000);
        check("rst_dc",    32'(dc_n), 32'hEEB);
        check("rst_up",    32'(cpulse_up), 0);
        check("rst_dn",    32'(cpulse_dn), 0);
        check("rst_err",   32'(coarse_err), 0);
        check("rst_fault", 32'(tlc_fault), 0);
        rst = 1'b0;

        // Idle: nulled comparators, no ADHI -> nothing moves.
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (cpulse_up || cpulse_dn || coarse_err) pulses++;
        end
        check("idle_events", 32'(pulses), 0);
        check("idle_cnt",    32'(cnt), 32'h0000);
        check("idle_dc",     32'(dc_n), 32'hEEB);

        // Decode table: load, cnt on the next edge, switches one edge later.
        for (int i = 0; i < 10; i++) begin
            do_load(vecs[i].load_val);
            check($sformatf("tbl_cnt[%0d]", i), 32'(cnt), 32'(vecs[i].load_val));
            tick();
            check($sformatf("tbl_dc[%0d]", i), 32'(dc_n), 32'(vecs[i].dc_n));
        end

        // Slew up from reset. SAMPLE is entered at edge 11 after reset
        // (3 priming + 8 settle); its step registers at edge 12.
        rst = 1'b1; tlc1_n = 1'b0;
        tick(); tick();
        rst = 1'b0;
        wait_for(0, 40, n);
        check("up_first", 32'(n), 12);
        check("up_cnt1",  32'(cnt), 32'h0040);
        for (int k = 2; k <= 8; k++) begin
            wait_for(0, 40, n);
            check($sformatf("up_gap%0d", k), 32'(n), 9);
        end
        check("up_cnt8", 32'(cnt), 32'h0200);
        tick();
        check("up_dc12", 32'(dc_n), 32'h6EB);
        // Switch change restarts the timer: 10 cycles after pulse 8, one spent.
        wait_for(0, 40, n);
        check("up_gap9", 32'(n), 9);
        check("up_cnt9", 32'(cnt), 32'h0240);

        // Slew down across zero.
        tlc1_n = 1'b1; tlc2_n = 1'b0;
        do_load(16'h0020);
        wait_for(1, 40, n);
        check("dn_lat",  32'(n), 10);
        check("dn_cnt",  32'(cnt), 32'hFFE0);
        tlc2_n = 1'b1;
        tick();
        check("dn_dc",   32'(dc_n), 32'h1F5);
        check("dn_err",  32'(coarse_err), 1);

        // Ambiguity flip after four nulled samples with ADHI high.
        adhi = 1'b1;
        do_load(16'h1234);
        n = -1;
        for (int i = 1; i <= 60; i++) begin
            tick();
            if (cnt != 16'h1234) begin
                n = i;
                break;
            end
        end
        adhi = 1'b0;
        check("flip_lat", 32'(n), 37);
        check("flip_cnt", 32'(cnt), 32'h9234);

        // ADHI low on the third sample clears the filter: no flip.
        adhi = 1'b1;
        do_load(16'h1234);
        for (int i = 1; i <= 50; i++) begin
            if (i == 21) adhi = 1'b0;
            if (i == 31) adhi = 1'b1;
            tick();
        end
        adhi = 1'b0;
        check("noflip_cnt", 32'(cnt), 32'h1234);

        // Both comparators asserted: fault, no step, fine dropped.
        tlc1_n = 1'b0; tlc2_n = 1'b0;
        do_load(16'h0100);
        wait_for(2, 30, n);
        check("fault_lat", 32'(n), 10);
        check("fault_cnt", 32'(cnt), 32'h0100);
        check("fault_err", 32'(coarse_err), 1);
        fine_up = 1'b1;
        tick();
        fine_up = 1'b0;
        check("fault_fine_drop", 32'(cnt), 32'h0100);
        tlc1_n = 1'b1; tlc2_n = 1'b1;
        wait_for(3, 30, n);
        check("fault_clear_lat", 32'(n), 8);
        check("fault_clear",     32'(tlc_fault), 0);

        // Fine pulses.
        fine_up = 1'b1;
        tick(); tick(); tick();
        fine_up = 1'b0;
        check("fine_up3", 32'(cnt), 32'h0103);
        fine_up = 1'b1; tlc1_n = 1'b0;
        do_load(16'h0500);
        fine_up = 1'b0;
        check("fine_vs_load", 32'(cnt), 32'h0500);
        fine_up = 1'b1; fine_dn = 1'b1;
        tick();
        fine_up = 1'b0; fine_dn = 1'b0;
        check("fine_cancel", 32'(cnt), 32'h0500);
        for (int i = 0; i < 8; i++) tick();
        fine_up = 1'b1;
        tick();
        fine_up = 1'b0; tlc1_n = 1'b1;
        check("fine_in_step_cnt",   32'(cnt), 32'h0540);
        check("fine_in_step_pulse", 32'(cpulse_up), 1);
        fine_up = 1'b1;
        tick();
        fine_up = 1'b0;
        check("fine_err_drop", 32'(cnt), 32'h0540);

        // Reset overrides a coincident load.
        rst = 1'b1; load = 1'b1; load_val = 16'hABCD;
        tick();
        rst = 1'b0; load = 1'b0;
        check("rst_load_cnt", 32'(cnt), 32'h0000);
        check("rst_load_dc",  32'(dc_n), 32'hEEB);
        check("rst_load_err", 32'(coarse_err), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
